// File: rtl/trap_sequencer.sv
// Trap sequencer: takes prioritised traps from decode, squashes younger work,
// hands a trap vector to fetch, then stalls while the pipeline refills.
module trap_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [3:0]  VEC_BASE     = 4'h8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pipe_valid,
  input  logic       GStrap,
  input  logic       trapinstr,
  input  logic       TAGtrap,
  input  logic       pov_unflow,
  input  logic       skipCONDenable,
  input  logic       cond_true,
  input  logic       fetch_ready,
  output logic       squash,
  output logic       stall,
  output logic       trap_valid,
  output logic [7:0] trap_vector,
  output logic       skip_next,
  output logic       busy,
  output logic [7:0] trap_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUASH = 2'd1,
    VECTOR = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t     state, state_next;
  logic [3:0] cause, cause_next;
  logic [3:0] drain_cnt, drain_cnt_next;
  logic [7:0] count_q, count_next;
  logic       skip_q, skip_q_next;

  logic       any_trap;
  logic       take_trap;
  logic       skip_cond;
  logic [3:0] cause_sel;

  // Trap and skip requests only matter while idle; everything else ignores them.
  always_comb begin
    any_trap  = TAGtrap | pov_unflow | GStrap | trapinstr;
    take_trap = (state == IDLE) & pipe_valid & any_trap;
    skip_cond = (state == IDLE) & pipe_valid & skipCONDenable & cond_true & ~any_trap;

    cause_sel = 4'h0;
    if (TAGtrap) begin
      cause_sel = 4'h1;
    end else if (pov_unflow) begin
      cause_sel = 4'h2;
    end else if (GStrap) begin
      cause_sel = 4'h3;
    end else if (trapinstr) begin
      cause_sel = 4'h4;
    end
  end

  always_comb begin
    state_next     = state;
    cause_next     = cause;
    drain_cnt_next = drain_cnt;
    count_next     = count_q;
    skip_q_next    = skip_cond;

    case (state)
      IDLE: begin
        if (take_trap) begin
          state_next = SQUASH;
          cause_next = cause_sel;
        end
      end
      SQUASH: begin
        state_next = VECTOR;
      end
      VECTOR: begin
        if (fetch_ready) begin
          state_next     = DRAIN;
          drain_cnt_next = DRAIN_LOAD;
          count_next     = (count_q == 8'hFF) ? 8'hFF : count_q + 8'h01;
        end
      end
      DRAIN: begin
        // The load value counts the first drain cycle, so leave on the last one.
        if (drain_cnt <= 4'h1) begin
          state_next     = IDLE;
          drain_cnt_next = 4'h0;
        end else begin
          drain_cnt_next = drain_cnt - 4'h1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cause     <= 4'h0;
      drain_cnt <= 4'h0;
      count_q   <= 8'h00;
      skip_q    <= 1'b0;
    end else begin
      state     <= state_next;
      cause     <= cause_next;
      drain_cnt <= drain_cnt_next;
      count_q   <= count_next;
      skip_q    <= skip_q_next;
    end
  end

  // Every output is a decode of registered state, so there is no input-to-output path.
  assign squash      = (state == SQUASH);
  assign stall       = (state != IDLE);
  assign trap_valid  = (state == VECTOR);
  assign busy        = (state != IDLE);
  assign skip_next   = skip_q & (state == IDLE);
  assign trap_vector = {VEC_BASE, cause};
  assign trap_count  = count_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer (DRAIN_CYCLES=2, VEC_BASE=4'h8).
module tb_trap_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pipe_valid;
  logic       GStrap, trapinstr, TAGtrap, pov_unflow;
  logic       skipCONDenable, cond_true, fetch_ready;
  logic       squash, stall, trap_valid, skip_next, busy;
  logic [7:0] trap_vector, trap_count;

  int vectors = 0;
  int errors  = 0;

  trap_sequencer #(.DRAIN_CYCLES(2), .VEC_BASE(4'h8)) dut (
    .clk(clk), .reset(reset), .pipe_valid(pipe_valid),
    .GStrap(GStrap), .trapinstr(trapinstr), .TAGtrap(TAGtrap), .pov_unflow(pov_unflow),
    .skipCONDenable(skipCONDenable), .cond_true(cond_true), .fetch_ready(fetch_ready),
    .squash(squash), .stall(stall), .trap_valid(trap_valid), .trap_vector(trap_vector),
    .skip_next(skip_next), .busy(busy), .trap_count(trap_count)
  );

  always #5 clk = ~clk;

  // status = {squash, stall, trap_valid, skip_next, busy}
  wire [4:0] status = {squash, stall, trap_valid, skip_next, busy};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pipe_valid = 0; GStrap = 0; trapinstr = 0; TAGtrap = 0; pov_unflow = 0;
    skipCONDenable = 0; cond_true = 0; fetch_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    TAGtrap = 1; pipe_valid = 1; fetch_ready = 1;
    reset = 1;
    step(); step();
    vectors++;
    if (status !== 5'b00000) begin errors++; $display("[TB] FAIL reset_status got %b want %b", status, 5'b00000); end
    vectors++;
    if (trap_vector !== 8'h80) begin errors++; $display("[TB] FAIL reset_vector got %h want %h", trap_vector, 8'h80); end
    vectors++;
    if (trap_count !== 8'h00) begin errors++; $display("[TB] FAIL reset_count got %h want %h", trap_count, 8'h00); end
    clear_inputs();
    reset = 0;
    step();
  endtask

  task automatic test_priority();
    pipe_valid = 1; TAGtrap = 1; GStrap = 1; fetch_ready = 1;
    step();
    clear_inputs(); fetch_ready = 1;
    vectors++;
    if (status !== 5'b11001) begin errors++; $display("[TB] FAIL prio_squash got %b want %b", status, 5'b11001); end
    step();
    vectors++;
    if (status !== 5'b01101 || trap_vector !== 8'h81) begin
      errors++; $display("[TB] FAIL prio_vector got %b/%h want %b/%h", status, trap_vector, 5'b01101, 8'h81);
    end
    step();
    vectors++;
    if (status !== 5'b01001 || trap_count !== 8'h01) begin
      errors++; $display("[TB] FAIL prio_drain1 got %b/%h want %b/%h", status, trap_count, 5'b01001, 8'h01);
    end
    step();
    vectors++;
    if (status !== 5'b01001) begin errors++; $display("[TB] FAIL prio_drain2 got %b want %b", status, 5'b01001); end
    step();
    vectors++;
    if (status !== 5'b00000 || trap_count !== 8'h01) begin
      errors++; $display("[TB] FAIL prio_idle got %b/%h want %b/%h", status, trap_count, 5'b00000, 8'h01);
    end
    clear_inputs();
  endtask

  task automatic test_fetch_backpressure();
    pipe_valid = 1; trapinstr = 1;
    step();
    clear_inputs();
    vectors++;
    if (status !== 5'b11001 || trap_vector !== 8'h84) begin
      errors++; $display("[TB] FAIL bp_squash got %b/%h want %b/%h", status, trap_vector, 5'b11001, 8'h84);
    end
    step();
    for (int i = 0; i < 6; i++) begin
      fetch_ready = (i == 5);
      vectors++;
      if (status !== 5'b01101 || trap_vector !== 8'h84) begin
        errors++; $display("[TB] FAIL bp_hold%0d got %b/%h want %b/%h", i, status, trap_vector, 5'b01101, 8'h84);
      end
      step();
    end
    fetch_ready = 0;
    vectors++;
    if (status !== 5'b01001 || trap_count !== 8'h02) begin
      errors++; $display("[TB] FAIL bp_drain got %b/%h want %b/%h", status, trap_count, 5'b01001, 8'h02);
    end
    step(); step();
    vectors++;
    if (status !== 5'b00000) begin errors++; $display("[TB] FAIL bp_idle got %b want %b", status, 5'b00000); end
  endtask

  task automatic test_skip();
    pipe_valid = 1; skipCONDenable = 1; cond_true = 1;
    step();
    clear_inputs();
    vectors++;
    if (status !== 5'b00010) begin errors++; $display("[TB] FAIL skip_pulse got %b want %b", status, 5'b00010); end
    step();
    vectors++;
    if (status !== 5'b00000) begin errors++; $display("[TB] FAIL skip_once got %b want %b", status, 5'b00000); end
    pipe_valid = 1; skipCONDenable = 1; cond_true = 1; pov_unflow = 1;
    step();
    clear_inputs(); fetch_ready = 1;
    vectors++;
    if (status !== 5'b11001 || trap_vector !== 8'h82) begin
      errors++; $display("[TB] FAIL skip_trapwins got %b/%h want %b/%h", status, trap_vector, 5'b11001, 8'h82);
    end
    step(); step(); step(); step();
    vectors++;
    if (status !== 5'b00000 || trap_count !== 8'h03) begin
      errors++; $display("[TB] FAIL skip_trapdone got %b/%h want %b/%h", status, trap_count, 5'b00000, 8'h03);
    end
    clear_inputs();
  endtask

  task automatic test_ignore_while_busy();
    pipe_valid = 1; GStrap = 1;
    step();
    TAGtrap = 1; pov_unflow = 1; trapinstr = 1; skipCONDenable = 1; cond_true = 1;
    vectors++;
    if (status !== 5'b11001 || trap_vector !== 8'h83) begin
      errors++; $display("[TB] FAIL ign_squash got %b/%h want %b/%h", status, trap_vector, 5'b11001, 8'h83);
    end
    step();
    GStrap = 0; TAGtrap = 0;
    step();
    TAGtrap = 1; GStrap = 1;
    vectors++;
    if (status !== 5'b01101 || trap_vector !== 8'h83) begin
      errors++; $display("[TB] FAIL ign_vector got %b/%h want %b/%h", status, trap_vector, 5'b01101, 8'h83);
    end
    fetch_ready = 1;
    step();
    vectors++;
    if (status !== 5'b01001 || trap_count !== 8'h04 || trap_vector !== 8'h83) begin
      errors++; $display("[TB] FAIL ign_drain got %b/%h/%h want %b/%h/%h", status, trap_count, trap_vector, 5'b01001, 8'h04, 8'h83);
    end
    step();
    clear_inputs();
    step();
    vectors++;
    if (status !== 5'b00000 || trap_count !== 8'h04 || trap_vector !== 8'h83) begin
      errors++; $display("[TB] FAIL ign_idle got %b/%h/%h want %b/%h/%h", status, trap_count, trap_vector, 5'b00000, 8'h04, 8'h83);
    end
  endtask

  task automatic test_reset_mid_vector();
    reset = 1;
    step();
    reset = 0;
    pipe_valid = 1; trapinstr = 1;
    step();
    clear_inputs();
    step();
    vectors++;
    if (status !== 5'b01101) begin errors++; $display("[TB] FAIL rstv_invector got %b want %b", status, 5'b01101); end
    reset = 1; fetch_ready = 1;
    step();
    vectors++;
    if (status !== 5'b00000 || trap_vector !== 8'h80 || trap_count !== 8'h00) begin
      errors++; $display("[TB] FAIL rstv_abandon got %b/%h/%h want %b/%h/%h", status, trap_vector, trap_count, 5'b00000, 8'h80, 8'h00);
    end
    reset = 0;
    clear_inputs();
    step();
  endtask

  task automatic test_pipe_invalid();
    GStrap = 1; trapinstr = 1; TAGtrap = 1; pov_unflow = 1;
    skipCONDenable = 1; cond_true = 1; fetch_ready = 1; pipe_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (status !== 5'b00000 || trap_count !== 8'h00 || trap_vector !== 8'h80) begin
        errors++; $display("[TB] FAIL pinv%0d got %b/%h/%h want %b/%h/%h", i, status, trap_count, trap_vector, 5'b00000, 8'h00, 8'h80);
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    pipe_valid = 1; TAGtrap = 1; fetch_ready = 1;
    for (int k = 1; k <= 260; k++) begin
      for (int c = 0; c < 5; c++) step();
      if (k == 1 || k == 128 || k == 255 || k == 260) begin
        want = (k >= 255) ? 8'hFF : 8'(k);
        vectors++;
        if (trap_count !== want || status !== 5'b00000) begin
          errors++; $display("[TB] FAIL b2b_count%0d got %h/%b want %h/%b", k, trap_count, status, want, 5'b00000);
        end
      end
    end
    clear_inputs();
    step();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_priority();
    test_fetch_backpressure();
    test_skip();
    test_ignore_while_busy();
    test_reset_mid_vector();
    test_pipe_invalid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
